// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit owning HI/LO with busy-counter latency and D-stage stall
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CNT_W-1:0] counter;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_write;

  logic             arith_op;
  logic             start;
  logic             finish;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             div_signed;
  logic             div_by_zero;
  logic [31:0]      dividend_mag;
  logic [31:0]      divisor_mag;
  logic [31:0]      divisor_safe;
  logic [31:0]      quot_mag;
  logic [31:0]      rem_mag;
  logic [31:0]      quot;
  logic [31:0]      rem;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_write;
  logic [CNT_W-1:0] calc_load;

  // Decode: arithmetic ops only start when the unit is idle; anything issued while busy is dropped.
  always_comb begin
    arith_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
               (md_op == OP_DIV)  || (md_op == OP_DIVU);
    start    = arith_op && !busy;
    finish   = busy && (counter == CNT_ONE);
    md_stall = d_md_use && (busy || arith_op);
  end

  // Multiply: sign- or zero-extend to 64 bits so the low 64 bits of the product are exact.
  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows the
  // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0. A zero divisor is replaced by
  // one only to keep the divider well-defined; its result is never written.
  always_comb begin
    div_signed   = (md_op == OP_DIV);
    div_by_zero  = (rt_val == 32'd0);
    dividend_mag = (div_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    divisor_mag  = (div_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    divisor_safe = div_by_zero ? 32'd1 : divisor_mag;
    quot_mag     = dividend_mag / divisor_safe;
    rem_mag      = dividend_mag % divisor_safe;
    quot         = (div_signed && (rs_val[31] ^ rt_val[31])) ? (~quot_mag + 32'd1) : quot_mag;
    rem          = (div_signed && rs_val[31]) ? (~rem_mag + 32'd1) : rem_mag;
  end

  // Select the result, its write-enable and the busy duration for the op being started.
  always_comb begin
    calc_hi    = 32'd0;
    calc_lo    = 32'd0;
    calc_write = 1'b0;
    calc_load  = CNT_ZERO;
    case (md_op)
      OP_MULT: begin
        calc_hi    = prod_s[63:32];
        calc_lo    = prod_s[31:0];
        calc_write = 1'b1;
        calc_load  = MULT_LOAD;
      end
      OP_MULTU: begin
        calc_hi    = prod_u[63:32];
        calc_lo    = prod_u[31:0];
        calc_write = 1'b1;
        calc_load  = MULT_LOAD;
      end
      OP_DIV, OP_DIVU: begin
        calc_hi    = rem;
        calc_lo    = quot;
        calc_write = !div_by_zero;
        calc_load  = DIV_LOAD;
      end
      default: begin
        calc_hi    = 32'd0;
        calc_lo    = 32'd0;
        calc_write = 1'b0;
        calc_load  = CNT_ZERO;
      end
    endcase
  end

  // Busy counter and held result: capture at start, count down, release on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      counter   <= CNT_ZERO;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      res_write <= 1'b0;
    end else if (start) begin
      busy      <= 1'b1;
      counter   <= calc_load;
      res_hi    <= calc_hi;
      res_lo    <= calc_lo;
      res_write <= calc_write;
    end else if (finish) begin
      busy      <= 1'b0;
      counter   <= CNT_ZERO;
    end else if (busy) begin
      counter   <= counter - CNT_ONE;
    end
  end

  // HI/LO: the held result lands at completion; mthi/mtlo write directly only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (finish) begin
      if (res_write) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (!busy && (md_op == OP_MTHI)) begin
      hi <= rs_val;
    end else if (!busy && (md_op == OP_MTLO)) begin
      lo <= rs_val;
    end
  end

endmodule
